// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch sequencer
// Holds the FSM state encoding, the default PC width, the wait/flush counter
// width and the legal ranges of the latency/flush parameters, plus helpers
// that turn a parameter into a counter preload value.
package fetch_pkg;

  localparam int FETCH_PC_W       = 32;
  localparam int CNT_W            = 4;

  localparam int IMEM_LAT_MIN     = 0;
  localparam int IMEM_LAT_MAX     = 15;
  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 7;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_FLUSH    = 3'd4
  } fetch_state_t;

  // Keeps an out-of-range parameter inside the range the counters can express.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Counter preload for a phase of `total` cycles of which `consumed` are
  // spent before the counter starts counting; the counter exits at zero.
  function automatic logic [CNT_W-1:0] cnt_preload(input int total, input int consumed);
    if (total > consumed) return CNT_W'(total - consumed);
    return '0;
  endfunction

endpackage

// File: rtl/ctrl_down_cnt.sv
// rtl/ctrl_down_cnt.sv - loadable down-counter with zero flag
// Ports:
//   clk, rst      clock, synchronous active-high reset (count -> 0)
//   load,load_val load takes priority over decrement
//   dec           decrement by one, saturating at zero
//   zero          count is currently zero
module ctrl_down_cnt
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencing controller
// Decides each cycle whether the PC advances, whether the next-PC mux takes
// the latched branch target, and whether IF/ID is written or flushed.
// Optional macro FETCH_PERF_CNT_EN adds stall_cnt / redirect_cnt outputs.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lw_hazard          load-use stall request from ID
//   branch_taken       resolved taken branch, sampled every cycle
//   branch_PC          branch target, valid with branch_taken
//   pc_write           PC register load enable
//   mux_ctrl           next-PC select (1 = redirect_PC, 0 = PC+1)
//   redirect_PC        latched branch target
//   if_id_write        IF/ID load enable
//   if_id_flush        IF/ID clear
//   fetch_valid        instruction-memory output is a valid fetch
//   stall_cnt          (FETCH_PERF_CNT_EN) load-use stall cycles
//   redirect_cnt       (FETCH_PERF_CNT_EN) entries into redirect
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W         = FETCH_PC_W,
  parameter int IMEM_LAT     = 0,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lw_hazard,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_PC,
  output logic            pc_write,
  output logic            mux_ctrl,
  output logic [PC_W-1:0] redirect_PC,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     redirect_cnt
`endif
);

  localparam int IMEM_LAT_C     = clamp_int(IMEM_LAT, IMEM_LAT_MIN, IMEM_LAT_MAX);
  localparam int FLUSH_CYCLES_C = clamp_int(FLUSH_CYCLES, FLUSH_CYCLES_MIN, FLUSH_CYCLES_MAX);

  // The FETCH cycle is the first of the IMEM_LAT+1 cycles of a fetch, and the
  // REDIRECT cycle is the first of the FLUSH_CYCLES flush cycles.
  localparam logic [CNT_W-1:0] WAIT_PRELOAD  = cnt_preload(IMEM_LAT_C, 1);
  localparam logic [CNT_W-1:0] FLUSH_PRELOAD = cnt_preload(FLUSH_CYCLES_C, 2);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         capture;
  logic         wait_load;
  logic         wait_zero;
  logic         flush_load;
  logic         flush_zero;

  ctrl_down_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (WAIT_PRELOAD),
    .dec      (state_q == ST_WAIT),
    .zero     (wait_zero)
  );

  ctrl_down_cnt u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (flush_load),
    .load_val (FLUSH_PRELOAD),
    .dec      (state_q == ST_FLUSH),
    .zero     (flush_zero)
  );

  // State register and branch-target latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      redirect_PC <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        redirect_PC <= branch_PC;
      end
    end
  end

  // Next-state logic; a taken branch outranks everything except BOOT
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    wait_load  = 1'b0;
    flush_load = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          capture = 1'b1;
          state_d = ST_REDIRECT;
        end else if (lw_hazard) begin
          state_d = ST_FETCH;
        end else if (IMEM_LAT_C > 0) begin
          wait_load = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          capture = 1'b1;
          state_d = ST_REDIRECT;
        end else if (wait_zero) begin
          state_d = ST_FETCH;
        end
      end
      ST_REDIRECT: begin
        if (branch_taken) begin
          capture = 1'b1;
          state_d = ST_REDIRECT;
        end else if (FLUSH_CYCLES_C == 1) begin
          state_d = ST_FETCH;
        end else begin
          flush_load = 1'b1;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (branch_taken) begin
          capture = 1'b1;
          state_d = ST_REDIRECT;
        end else if (flush_zero) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    pc_write    = 1'b0;
    mux_ctrl    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    fetch_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          fetch_valid = 1'b1;
          pc_write    = ~lw_hazard & ~branch_taken;
          if_id_write = ~lw_hazard & ~branch_taken;
        end
        ST_REDIRECT: begin
          pc_write    = 1'b1;
          mux_ctrl    = 1'b1;
          if_id_flush = 1'b1;
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Re-captures while already in REDIRECT are not new entries
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if ((state_q == ST_FETCH) && lw_hazard && !branch_taken) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((state_d == ST_REDIRECT) && (state_q != ST_REDIRECT)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam int PC_W  = 32;
  localparam int LAT_A = 0;
  localparam int FC_A  = 3;
  localparam int LAT_B = 2;
  localparam int FC_B  = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lw_hazard = 1'b0;
  logic            branch_taken = 1'b0;
  logic [PC_W-1:0] branch_pc = '0;

  logic            a_pc_write, a_mux_ctrl, a_if_id_write, a_if_id_flush, a_fetch_valid;
  logic            b_pc_write, b_mux_ctrl, b_if_id_write, b_if_id_flush, b_fetch_valid;
  logic [PC_W-1:0] a_redirect_pc, b_redirect_pc;
  logic [4:0]      a_ctl, b_ctl;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     a_stall_cnt, a_redirect_cnt, b_stall_cnt, b_redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_ctl = {a_pc_write, a_mux_ctrl, a_if_id_write, a_if_id_flush, a_fetch_valid};
  assign b_ctl = {b_pc_write, b_mux_ctrl, b_if_id_write, b_if_id_flush, b_fetch_valid};

  fetch_ctrl #(.PC_W(PC_W), .IMEM_LAT(LAT_A), .FLUSH_CYCLES(FC_A)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .lw_hazard    (lw_hazard),
    .branch_taken (branch_taken),
    .branch_PC    (branch_pc),
    .pc_write     (a_pc_write),
    .mux_ctrl     (a_mux_ctrl),
    .redirect_PC  (a_redirect_pc),
    .if_id_write  (a_if_id_write),
    .if_id_flush  (a_if_id_flush),
    .fetch_valid  (a_fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt    (a_stall_cnt),
    .redirect_cnt (a_redirect_cnt)
`endif
  );

  fetch_ctrl #(.PC_W(PC_W), .IMEM_LAT(LAT_B), .FLUSH_CYCLES(FC_B)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .lw_hazard    (lw_hazard),
    .branch_taken (branch_taken),
    .branch_PC    (branch_pc),
    .pc_write     (b_pc_write),
    .mux_ctrl     (b_mux_ctrl),
    .redirect_PC  (b_redirect_pc),
    .if_id_write  (b_if_id_write),
    .if_id_flush  (b_if_id_flush),
    .fetch_valid  (b_fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt    (b_stall_cnt),
    .redirect_cnt (b_redirect_cnt)
`endif
  );

  // Reference model: remaining-cycle bookkeeping per instance (0 = A, 1 = B)
  int              lat [2] = '{LAT_A, LAT_B};
  int              fc  [2] = '{FC_A, FC_B};
  int              m_boot  [2] = '{1, 1};
  int              m_redir [2] = '{0, 0};
  int              m_flush [2] = '{0, 0};
  int              m_wait  [2] = '{0, 0};
  logic [PC_W-1:0] m_rpc   [2] = '{'0, '0};
  int unsigned     m_stall [2] = '{0, 0};
  int unsigned     m_rcnt  [2] = '{0, 0};

  // {pc_write, mux_ctrl, if_id_write, if_id_flush, fetch_valid}
  function automatic logic [4:0] exp_ctl(input int i);
    logic go;
    go = ~lw_hazard & ~branch_taken;
    if (rst || m_boot[i] != 0) return 5'b00000;
    if (m_redir[i] != 0)       return 5'b11010;
    if (m_flush[i] > 0)        return 5'b00010;
    if (m_wait[i] > 0)         return 5'b00000;
    return {go, 1'b0, go, 1'b0, 1'b1};
  endfunction

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_boot[i] = 1; m_redir[i] = 0; m_flush[i] = 0; m_wait[i] = 0;
        m_rpc[i] = '0; m_stall[i] = 0; m_rcnt[i] = 0;
      end else if (m_boot[i] != 0) begin
        m_boot[i] = 0;
      end else if (branch_taken) begin
        if (m_redir[i] == 0) m_rcnt[i]++;
        m_redir[i] = 1;
        m_flush[i] = fc[i] - 1;
        m_wait[i]  = 0;
        m_rpc[i]   = branch_pc;
      end else if (m_redir[i] != 0) begin
        m_redir[i] = 0;
      end else if (m_flush[i] > 0) begin
        m_flush[i]--;
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
      end else if (lw_hazard) begin
        m_stall[i]++;
      end else begin
        m_wait[i] = lat[i];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic l, input logic b, input logic [PC_W-1:0] pc);
    rst = r; lw_hazard = l; branch_taken = b; branch_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, '0);
    advance();
    set_in(1'b0, 1'b0, 1'b0, '0);
    advance();
  endtask

  task automatic test_reset();
    logic [4:0] exp_a;
    for (int c = 0; c < 7; c++) begin
      set_in(c < 2, 1'b0, 1'b0, '0);
      exp_a = (c < 3) ? 5'b00000 : 5'b10101;
      checks++;
      if (a_ctl !== exp_a || a_redirect_pc !== '0) begin
        errors++;
        $display("FAIL reset_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=0", c, a_ctl, a_redirect_pc, exp_a);
      end
      checks++;
      if (b_ctl !== exp_ctl(1) || b_redirect_pc !== m_rpc[1]) begin
        errors++;
        $display("FAIL reset_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, exp_ctl(1), m_rpc[1]);
      end
      advance();
    end
  endtask

  task automatic test_lw_hazard();
    logic       lw_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] exp_a;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, lw_tab[c], 1'b0, '0);
      exp_a = lw_tab[c] ? 5'b00001 : 5'b10101;
      checks++;
      if (a_ctl !== exp_a) begin
        errors++;
        $display("FAIL lw_hazard_a cyc %0d ctl=%b expected %b", c, a_ctl, exp_a);
      end
      checks++;
      if (b_ctl !== exp_ctl(1)) begin
        errors++;
        $display("FAIL lw_hazard_b cyc %0d ctl=%b expected %b", c, b_ctl, exp_ctl(1));
      end
      advance();
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (a_stall_cnt !== 32'd2 || b_stall_cnt !== m_stall[1]) begin
      errors++;
      $display("FAIL stall_cnt a=%0d b=%0d expected a=2 b=%0d", a_stall_cnt, b_stall_cnt, m_stall[1]);
    end
`endif
  endtask

  task automatic test_branch_flush();
    logic       bt_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] ea_tab [5] = '{5'b00001, 5'b11010, 5'b00010, 5'b00010, 5'b10101};
    logic [PC_W-1:0] exp_rpc;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, 1'b0, bt_tab[c], 32'h40);
      exp_rpc = (c == 0) ? 32'h0 : 32'h40;
      checks++;
      if (a_ctl !== ea_tab[c] || a_redirect_pc !== exp_rpc) begin
        errors++;
        $display("FAIL branch_flush_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, a_ctl, a_redirect_pc, ea_tab[c], exp_rpc);
      end
      checks++;
      if (b_ctl !== exp_ctl(1) || b_redirect_pc !== m_rpc[1]) begin
        errors++;
        $display("FAIL branch_flush_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, exp_ctl(1), m_rpc[1]);
      end
      advance();
    end
  endtask

  task automatic test_wait();
    logic       bt_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] eb_tab [8] = '{5'b10101, 5'b00000, 5'b00000, 5'b10101,
                               5'b00000, 5'b00000, 5'b11010, 5'b10101};
    logic [PC_W-1:0] exp_rpc;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, 1'b0, bt_tab[c], 32'h10);
      exp_rpc = (c <= 5) ? 32'h0 : 32'h10;
      checks++;
      if (b_ctl !== eb_tab[c] || b_redirect_pc !== exp_rpc) begin
        errors++;
        $display("FAIL wait_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, eb_tab[c], exp_rpc);
      end
      checks++;
      if (a_ctl !== exp_ctl(0) || a_redirect_pc !== m_rpc[0]) begin
        errors++;
        $display("FAIL wait_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, a_ctl, a_redirect_pc, exp_ctl(0), m_rpc[0]);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic            bt_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [PC_W-1:0] pc_tab [6] = '{32'h20, 32'h30, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [4:0]      ea_tab [6] = '{5'b00001, 5'b11010, 5'b11010, 5'b00010, 5'b00010, 5'b10101};
    logic [PC_W-1:0] er_tab [6] = '{32'h0, 32'h20, 32'h30, 32'h30, 32'h30, 32'h30};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(1'b0, 1'b0, bt_tab[c], pc_tab[c]);
      checks++;
      if (a_ctl !== ea_tab[c] || a_redirect_pc !== er_tab[c]) begin
        errors++;
        $display("FAIL back_to_back_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, a_ctl, a_redirect_pc, ea_tab[c], er_tab[c]);
      end
      checks++;
      if (b_ctl !== exp_ctl(1) || b_redirect_pc !== m_rpc[1]) begin
        errors++;
        $display("FAIL back_to_back_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, exp_ctl(1), m_rpc[1]);
      end
      advance();
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (a_redirect_cnt !== 32'd1) begin
      errors++;
      $display("FAIL redirect_cnt a=%0d expected 1", a_redirect_cnt);
    end
`endif
  endtask

  task automatic test_reset_in_flush();
    logic            rs_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic            bt_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0]      ea_tab [5] = '{5'b00001, 5'b11010, 5'b00000, 5'b00000, 5'b10101};
    logic [PC_W-1:0] er_tab [5] = '{32'h0, 32'h40, 32'h40, 32'h0, 32'h0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(rs_tab[c], 1'b0, bt_tab[c], 32'h40);
      checks++;
      if (a_ctl !== ea_tab[c] || a_redirect_pc !== er_tab[c]) begin
        errors++;
        $display("FAIL reset_in_flush_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, a_ctl, a_redirect_pc, ea_tab[c], er_tab[c]);
      end
      checks++;
      if (b_ctl !== exp_ctl(1) || b_redirect_pc !== m_rpc[1]) begin
        errors++;
        $display("FAIL reset_in_flush_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, exp_ctl(1), m_rpc[1]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic r, l, b;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      set_in(r, l, b, $urandom);
      checks++;
      if (a_ctl !== exp_ctl(0) || a_redirect_pc !== m_rpc[0]) begin
        errors++;
        $display("FAIL random_a cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, a_ctl, a_redirect_pc, exp_ctl(0), m_rpc[0]);
      end
      checks++;
      if (b_ctl !== exp_ctl(1) || b_redirect_pc !== m_rpc[1]) begin
        errors++;
        $display("FAIL random_b cyc %0d ctl=%b rpc=%h expected ctl=%b rpc=%h", c, b_ctl, b_redirect_pc, exp_ctl(1), m_rpc[1]);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (a_stall_cnt !== m_stall[0] || a_redirect_cnt !== m_rcnt[0] ||
          b_stall_cnt !== m_stall[1] || b_redirect_cnt !== m_rcnt[1]) begin
        errors++;
        $display("FAIL random_perf cyc %0d a=%0d/%0d b=%0d/%0d expected a=%0d/%0d b=%0d/%0d", c,
                 a_stall_cnt, a_redirect_cnt, b_stall_cnt, b_redirect_cnt,
                 m_stall[0], m_rcnt[0], m_stall[1], m_rcnt[1]);
      end
`endif
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, '0);
    advance();
    test_reset();
    test_lw_hazard();
    test_branch_flush();
    test_wait();
    test_back_to_back();
    test_reset_in_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
